// File: rtl/mc_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module      : mc_cmd_receiver
// Description : Memory-controller end of the cache-to-controller command
//               channel. A two-state handshake FSM accepts commands offered on
//               valid_tran, answers each with a one-cycle ack_tran and a tag,
//               and queues {rw, addr, data, tag} in a 2**TAGW-entry FIFO that
//               drains to the scheduler over a valid/ready port.
// Ports       : clock, reset (async, active-low)
//               valid_tran, rw, addr, data_tran  -> command offer
//               ack_tran, tag_tran, full         <- handshake / back-pressure
//               deq_valid, deq_ready, deq_rw, deq_addr, deq_data, deq_tag
//                                                 <-> scheduler dequeue port
// Revision    : 1.0 - initial release
// ============================================================================
module mc_cmd_receiver #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 32,
    parameter int TAGW   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_tran,
    input  logic              rw,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] data_tran,
    output logic              ack_tran,
    output logic [TAGW-1:0]   tag_tran,
    output logic              full,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic              deq_rw,
    output logic [AWIDTH-1:0] deq_addr,
    output logic [DWIDTH-1:0] deq_data,
    output logic [TAGW-1:0]   deq_tag
);

    localparam int            c_DEPTH    = 2 ** TAGW;
    localparam logic [0:0]    c_IDLE     = 1'b0;
    localparam logic [0:0]    c_ACK      = 1'b1;
    localparam logic [TAGW-1:0] c_PTR_ONE = {{(TAGW-1){1'b0}}, 1'b1};
    localparam logic [TAGW:0] c_CNT_ONE  = {{TAGW{1'b0}}, 1'b1};
    localparam logic [TAGW:0] c_CNT_ZERO = '0;
    localparam logic [TAGW:0] c_CNT_FULL = {1'b1, {TAGW{1'b0}}};

    logic [0:0]      r_state;
    logic [TAGW-1:0] r_wr_ptr;
    logic [TAGW-1:0] r_rd_ptr;
    logic [TAGW:0]   r_count;
    logic            r_full;
    logic            r_deq_valid;
    logic            r_ack;
    logic [TAGW-1:0] r_tag_tran;

    logic              r_mem_rw   [c_DEPTH];
    logic [AWIDTH-1:0] r_mem_addr [c_DEPTH];
    logic [DWIDTH-1:0] r_mem_data [c_DEPTH];
    logic [TAGW-1:0]   r_mem_tag  [c_DEPTH];

    logic          w_push;
    logic          w_pop;
    logic [TAGW:0] w_count_nxt;

    // Push only from IDLE and only against the registered full flag, so a pop
    // on the same edge cannot open a slot for a command that is already full.
    assign w_push = (r_state == c_IDLE) && valid_tran && !r_full;
    assign w_pop  = r_deq_valid && deq_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Handshake FSM; ACK lasts exactly one cycle and ignores valid_tran, which
    // the transmitter is still holding high while it sees the ack.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_ack      <= 1'b0;
            r_tag_tran <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_push) begin
                        r_state    <= c_ACK;
                        r_ack      <= 1'b1;
                        r_tag_tran <= r_wr_ptr;
                    end else begin
                        r_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    // Pointers, occupancy and the registered status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_deq_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == c_CNT_FULL);
            r_deq_valid <= (w_count_nxt != c_CNT_ZERO);
        end
    end

    // Storage; the tag of an entry is simply the slot it lives in, which keeps
    // all outstanding tags unique.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem_rw[i]   <= 1'b0;
                r_mem_addr[i] <= '0;
                r_mem_data[i] <= '0;
                r_mem_tag[i]  <= '0;
            end
        end else if (w_push) begin
            r_mem_rw[r_wr_ptr]   <= rw;
            r_mem_addr[r_wr_ptr] <= addr;
            r_mem_data[r_wr_ptr] <= data_tran;
            r_mem_tag[r_wr_ptr]  <= r_wr_ptr;
        end
    end

    assign ack_tran  = r_ack;
    assign tag_tran  = r_tag_tran;
    assign full      = r_full;
    assign deq_valid = r_deq_valid;
    assign deq_rw    = r_mem_rw[r_rd_ptr];
    assign deq_addr  = r_mem_addr[r_rd_ptr];
    assign deq_data  = r_mem_data[r_rd_ptr];
    assign deq_tag   = r_mem_tag[r_rd_ptr];

endmodule
`default_nettype wire
